// File: rtl/dot_product_accumulator.sv
// rtl/dot_product_accumulator.sv - sums DOT_LEN unsigned products into one dot-product element
module dot_product_accumulator #(
    parameter int PROD_W  = 64,
    parameter int DOT_LEN = 4,
    parameter int ACC_W   = 66
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PROD_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             out_data,
    output logic [$clog2(DOT_LEN+1)-1:0] elem_cnt
);

    localparam int CNT_W = $clog2(DOT_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DOT_LEN - 1);

    if (ACC_W < PROD_W + $clog2(DOT_LEN)) begin : g_acc_w_check
        $error("ACC_W too narrow for PROD_W and DOT_LEN");
    end
    if (DOT_LEN < 1 || DOT_LEN > 1024) begin : g_dot_len_check
        $error("DOT_LEN outside 1..1024");
    end

    typedef enum logic {
        ST_ACCUM,
        ST_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  prod_ext;
    logic              accept;

    always_comb begin
        prod_ext  = ACC_W'(in_data);
        in_ready  = (state_q == ST_ACCUM) && !clear;
        accept    = in_valid && in_ready;
        out_valid = (state_q == ST_HOLD);
        out_data  = acc_q;
        elem_cnt  = cnt_q;

        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        // clear outranks a same-cycle handshake: the held result is dropped, not transferred
        if (clear) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        acc_d = (cnt_q == '0) ? prod_ext : acc_q + prod_ext;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // acc is left alone; the next first beat overwrites it
                    if (out_ready) begin
                        state_d = ST_ACCUM;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_ACCUM;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// tb/tb_dot_product_accumulator.sv - scoreboard bench for dot_product_accumulator
module tb_dot_product_accumulator;

    localparam int PROD_W  = 64;
    localparam int DOT_LEN = 4;
    localparam int ACC_W   = 66;
    localparam int CNT_W   = $clog2(DOT_LEN + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PROD_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ACC_W-1:0]  out_data;
    logic [CNT_W-1:0]  elem_cnt;

    dot_product_accumulator #(
        .PROD_W (PROD_W),
        .DOT_LEN(DOT_LEN),
        .ACC_W  (ACC_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .elem_cnt (elem_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted beats of the current vector, and finished sums awaiting transfer
    logic [PROD_W-1:0] beats[$];
    logic [ACC_W-1:0]  exp_q[$];
    logic              m_hold = 1'b0;
    logic              took = 1'b0;
    logic [ACC_W-1:0]  ref_sum;
    logic [ACC_W-1:0]  last_out = '0;
    logic [ACC_W-1:0]  prev_out = '0;
    int                xfers = 0;

    always @(negedge clk) begin
        took = 1'b0;
        if (!rst_n) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            check("rst_elem_cnt", elem_cnt, 0);
            beats.delete();
            exp_q.delete();
            m_hold = 1'b0;
        end else begin
            check("in_ready", in_ready, !m_hold && !clear);
            check("out_valid", out_valid, m_hold);
            check("elem_cnt", elem_cnt, beats.size());
            if (m_hold && exp_q.size() > 0) begin
                check("out_data", out_data, exp_q[0]);
            end
            if (clear) begin
                if (m_hold && exp_q.size() > 0) void'(exp_q.pop_front());
                m_hold = 1'b0;
                beats.delete();
            end else if (m_hold) begin
                if (out_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    prev_out = last_out;
                    last_out = out_data;
                    xfers++;
                    m_hold = 1'b0;
                    beats.delete();
                end
            end else if (in_valid) begin
                beats.push_back(in_data);
                took = 1'b1;
                if (beats.size() == DOT_LEN) begin
                    ref_sum = '0;
                    foreach (beats[i]) ref_sum = ref_sum + ACC_W'(beats[i]);
                    exp_q.push_back(ref_sum);
                    m_hold = 1'b1;
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic send_beat(input logic [PROD_W-1:0] d);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 40 && !done; i++) begin
            cycle();
            done = took;
        end
        if (!done) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    int xfers_before;

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // 1: simple sum
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send_beat(PROD_W'(i));
        idle(3);
        check("t1_sum", last_out, 10);

        // 2: full-scale products, no wrap
        for (int i = 0; i < 4; i++) send_beat('1);
        idle(3);
        check("t2_sum", last_out, 66'h3_FFFF_FFFF_FFFF_FFFC);

        // 3: backpressure holds the result and blocks the pending beat
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_beat(PROD_W'(i));
        in_valid = 1'b1;
        in_data  = 7;
        repeat (5) cycle();
        out_ready = 1'b1;
        send_beat(7);
        for (int i = 0; i < 3; i++) send_beat(0);
        idle(3);
        check("t3_prev", prev_out, 10);
        check("t3_sum", last_out, 7);

        // 4: back-to-back vectors
        for (int i = 0; i < 4; i++) send_beat(3);
        send_beat(1);
        send_beat(0);
        send_beat(0);
        send_beat(1);
        idle(3);
        check("t4_first", prev_out, 12);
        check("t4_second", last_out, 2);

        // 5: reset mid-vector discards the partial sum
        send_beat(9);
        send_beat(9);
        #2 rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 4; i++) send_beat(5);
        idle(3);
        check("t5_sum", last_out, 20);

        // 6: clear refuses a beat, and drops a held result despite out_ready
        for (int i = 0; i < 3; i++) send_beat(2);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 100;
        cycle();
        clear    = 1'b0;
        in_valid = 1'b0;
        idle(1);
        check("t6_cnt_after_clear", elem_cnt, 0);
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_beat(PROD_W'(i));
        idle(1);
        xfers_before = xfers;
        out_ready = 1'b1;
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        idle(2);
        check("t6_no_transfer", xfers, xfers_before);
        send_beat(5);
        send_beat(5);
        send_beat(5);
        send_beat(6);
        idle(3);
        check("t6_sum", last_out, 21);

        // random traffic with backpressure, gaps and occasional clear
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = ($urandom % 8 == 0) ? '1 : {$urandom, $urandom};
            out_ready = ($urandom % 3) != 0;
            clear     = ($urandom % 50) == 0;
            cycle();
        end
        clear = 1'b0;
        out_ready = 1'b1;
        idle(4);
        check("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
